// File: rtl/onehot_to_bin_enc.sv
// Registered one-hot to binary encoder with legality flags, saturating multi-hot
// counter and a 2-entry skid buffer. Define ONEHOT_PRIORITY_RESOLVE_EN to resolve
// multi-hot vectors to their highest set bit instead of 0.
module onehot_to_bin_enc #(
    parameter int N     = 8,
    localparam int W    = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     onehot_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     bin_out,
    output logic             zero_flag,
    output logic             err_flag,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [W-1:0] bin;
        logic         zero;
        logic         err;
    } beat_t;

    function automatic beat_t encode(input logic [N-1:0] v);
        beat_t        b;
        logic [1:0]   cnt;
        logic [W-1:0] idx;
        cnt = 2'd0;
        idx = {W{1'b0}};
        // The last set bit visited is the highest, which is what priority resolve wants.
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = W'(i);
                if (cnt != 2'd2) begin
                    cnt = cnt + 2'd1;
                end else begin
                    cnt = cnt;
                end
            end else begin
                idx = idx;
            end
        end
        b.bin  = {W{1'b0}};
        b.zero = 1'b0;
        b.err  = 1'b0;
        case (cnt)
            2'd0: b.zero = 1'b1;
            2'd1: b.bin  = idx;
            default: begin
                b.err = 1'b1;
`ifdef ONEHOT_PRIORITY_RESOLVE_EN
                b.bin = idx;
`else
                b.bin = {W{1'b0}};
`endif
            end
        endcase
        return b;
    endfunction

    state_e           state_q, state_d;
    beat_t            main_q, main_d;
    beat_t            skid_q, skid_d;
    beat_t            enc_s;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             in_fire_s, out_fire_s;

    assign enc_s      = encode(onehot_in);
    assign in_fire_s  = in_valid && in_ready_q;
    assign out_fire_s = out_valid_q && out_ready;

    // Skid-buffer next state, payload steering and counter update.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_d = ST_ONE;
                    main_d  = enc_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && !out_fire_s) begin
                    state_d = ST_FULL;
                    skid_d  = enc_s;
                end else if (in_fire_s && out_fire_s) begin
                    main_d  = enc_s;
                end else if (out_fire_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);

        if (err_clr) begin
            err_cnt_d = {CNT_W{1'b0}};
        end else if (in_fire_s && enc_s.err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, payload and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = main_q.bin;
    assign zero_flag = main_q.zero;
    assign err_flag  = main_q.err;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_onehot_to_bin_enc.sv
// Directed self-checking bench for onehot_to_bin_enc (N=8, CNT_W=8).
module tb_onehot_to_bin_enc;

    logic       clk;
    logic       rst;
    logic [7:0] onehot_in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] bin_out;
    logic       zero_flag;
    logic       err_flag;
    logic       out_valid;
    logic       out_ready;
    logic       err_clr;
    logic [7:0] err_cnt;

    int checks;
    int failures;

`ifdef ONEHOT_PRIORITY_RESOLVE_EN
    localparam logic [2:0] MULTI_24_BIN = 3'd5;
`else
    localparam logic [2:0] MULTI_24_BIN = 3'd0;
`endif

    onehot_to_bin_enc #(.N(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .onehot_in (onehot_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .zero_flag (zero_flag),
        .err_flag  (err_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; onehot_in = 8'h00; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if (bin_out !== 3'd0) begin failures++; $display("FAIL reset_bin_out got=%0h exp=0", bin_out); end
        checks++; if ({zero_flag, err_flag} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%0b exp=00", {zero_flag, err_flag}); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_legal_sweep();
        logic [7:0] v;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            v = 8'h01 << k;
            onehot_in = v; in_valid = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b1 || bin_out !== 3'(k)) begin failures++; $display("FAIL sweep_bin k=%0d got=%0d valid=%0b exp=%0d", k, bin_out, out_valid, k); end
            checks++; if ({zero_flag, err_flag, in_ready} !== 3'b001) begin failures++; $display("FAIL sweep_flags k=%0d got=%0b exp=001", k, {zero_flag, err_flag, in_ready}); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sweep_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_zero();
        onehot_in = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, zero_flag, err_flag} !== 3'b110 || bin_out !== 3'd0) begin failures++; $display("FAIL zero_beat got=%0b/%0d exp=110/0", {out_valid, zero_flag, err_flag}, bin_out); end
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL zero_err_cnt got=%0d exp=0", err_cnt); end
        tick();
    endtask

    task automatic test_multi_hot();
        onehot_in = 8'h24; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, zero_flag, err_flag} !== 3'b101) begin failures++; $display("FAIL multi_flags got=%0b exp=101", {out_valid, zero_flag, err_flag}); end
        checks++; if (bin_out !== MULTI_24_BIN) begin failures++; $display("FAIL multi_bin got=%0d exp=%0d", bin_out, MULTI_24_BIN); end
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL multi_err_cnt got=%0d exp=1", err_cnt); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        onehot_in = 8'h01; in_valid = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || bin_out !== 3'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_first got=rdy%0b bin%0d v%0b exp=rdy1 bin0 v1", in_ready, bin_out, out_valid); end
        onehot_in = 8'h02;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
        onehot_in = 8'h04;
        tick();
        checks++; if (in_ready !== 1'b0 || bin_out !== 3'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall got=rdy%0b bin%0d v%0b exp=rdy0 bin0 v1", in_ready, bin_out, out_valid); end
        out_ready = 1'b1;
        tick();
        checks++; if (bin_out !== 3'd1 || out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_second got=bin%0d v%0b rdy%0b exp=bin1 v1 rdy1", bin_out, out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (bin_out !== 3'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_third got=bin%0d v%0b exp=bin2 v1", bin_out, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd1) begin failures++; $display("FAIL bp_drain got=v%0b cnt%0d exp=v0 cnt1", out_valid, err_cnt); end
    endtask

    task automatic test_saturation_clear();
        out_ready = 1'b1; onehot_in = 8'h81; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) begin
                checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d exp=255", err_cnt); end
            end
        end
        checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", err_cnt); end
        err_clr = 1'b1;
        tick();
        checks++; if (err_cnt !== 8'd0 || err_flag !== 1'b1) begin failures++; $display("FAIL clear_wins got=cnt%0d err%0b exp=cnt0 err1", err_cnt, err_flag); end
        err_clr = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL count_after_clear got=%0d exp=1", err_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; onehot_in = 8'h03; in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || err_cnt !== 8'd3) begin failures++; $display("FAIL pre_reset_full got=rdy%0b cnt%0d exp=rdy0 cnt3", in_ready, err_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0) begin failures++; $display("FAIL async_reset got=v%0b rdy%0b cnt%0d exp=v0 rdy1 cnt0", out_valid, in_ready, err_cnt); end
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%0b exp=0", out_valid); end
        onehot_in = 8'h80; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || bin_out !== 3'd7 || {zero_flag, err_flag} !== 2'b00) begin failures++; $display("FAIL post_reset_beat got=v%0b bin%0d exp=v1 bin7", out_valid, bin_out); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_legal_sweep();
        test_zero();
        test_multi_hot();
        test_backpressure();
        test_saturation_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_to_bin_enc.md
Name: onehot_to_bin_enc

Overview:
- Registered one-hot to binary encoder with valid/ready handshake.
- Sits downstream of the binary-to-one-hot decode stage and recovers the binary index from its one-hot vector for the next pipeline stage.
- Checks each vector for legality: all-zero and multi-hot inputs are flagged, and multi-hot inputs are counted.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- N, 8, one-hot input width (N >= 2).
- W, $clog2(N), binary output width (derived; do not override).
- CNT_W, 8, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- onehot_in  input  N  one-hot vector from the upstream decoder.
- in_valid  input  1  onehot_in is valid.
- in_ready  output  1  block can accept; registered.
- bin_out  output  W  encoded index.
- zero_flag  output  1  accepted vector was all-zero.
- err_flag  output  1  accepted vector had more than one bit set.
- out_valid  output  1  bin_out, zero_flag and err_flag are valid.
- out_ready  input  1  downstream accepts.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_W  saturating count of accepted multi-hot vectors.

Behaviour:
- Reset (asynchronous, active-high; clk and rst only):
  - out_valid=0, bin_out=0, zero_flag=0, err_flag=0, err_cnt=0, in_ready=1.
  - Both buffer entries are emptied.
  - Reset mid-transfer discards any buffered data with no output beat.
- Transfers:
  - An input transfer occurs when in_valid && in_ready at a clk edge.
  - An output transfer occurs when out_valid && out_ready.
- Encode (combinational on onehot_in, captured at the input transfer):
  - Exactly one bit k set: bin_out=k, zero_flag=0, err_flag=0.
  - All zero: bin_out=0, zero_flag=1, err_flag=0.
  - More than one bit set: err_flag=1, zero_flag=0, bin_out as defined under Optional Feature.
- Latency: 1 cycle. A beat accepted at edge t is presented with out_valid=1 after edge t.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register holds the presented beat, out_valid=1, in_ready=1.
  - FULL: main and skid registers both hold beats, in_ready=0.
- Transitions:
  - EMPTY + input transfer -> ONE.
  - ONE + input transfer, no output transfer -> FULL; the new beat goes to skid.
  - ONE + input and output transfer on the same edge -> ONE; the new beat goes to main.
  - ONE + output transfer only -> EMPTY.
  - FULL + output transfer -> ONE; skid moves to main. No input is possible in FULL.
- in_ready is driven from the state register only. It never depends combinationally on out_ready.
- Output stability: while out_valid=1 and out_ready=0, bin_out and both flags hold.
- Beat order is preserved. No beat is dropped or duplicated.
- err_cnt:
  - Increments by 1 on each input transfer with err_flag=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - err_clr=1 forces 0 on the next edge. If a clear and an increment fall on the same edge, the clear wins and the result is 0.
  - The count is independent of output backpressure.
- in_valid while in_ready=0 is ignored. The upstream stage holds its data until accepted.

Optional Feature:
- Macro: ONEHOT_PRIORITY_RESOLVE_EN.
- Defined: a multi-hot input resolves to the index of the highest set bit, e.g. 8'b0010_0100 -> bin_out=5. err_flag and err_cnt still assert and count.
- Undefined: a multi-hot input gives bin_out=0.
- All other behaviour is identical in both builds.

Test Plan:
- Legal sweep, N=8: after reset, drive onehot_in=1<<k for k=0..7 back-to-back with out_ready=1 -> 8 beats, bin_out=0..7 in order, one per cycle after the first, flags 0, in_ready stays 1.
- Zero input: onehot_in=8'h00 -> bin_out=0, zero_flag=1, err_flag=0, err_cnt unchanged.
- Multi-hot: onehot_in=8'h24 -> err_flag=1, err_cnt 0->1. bin_out=0 without the macro, 5 with ONEHOT_PRIORITY_RESOLVE_EN.
- Backpressure: send 8'h01, 8'h02, 8'h04 with out_ready=0 -> in_ready falls to 0 after two accepts. The third beat waits until out_ready=1, then the outputs are 0,1,2 in order with bin_out stable while stalled.
- Saturation and clear: 300 multi-hot beats -> err_cnt=255 and holds. err_clr=1 together with a multi-hot accept -> err_cnt=0.
- Reset mid-operation: assert rst in state FULL -> out_valid=0, in_ready=1, err_cnt=0 immediately (asynchronous). After release, the first new beat 8'h80 gives bin_out=7.
